// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO controller.
package sync_fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Wraps at depth-1 so any depth works, not only powers of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer-facing bus of the FIFO. master = user side, slave = FIFO side.
// Valid/ready semantics: wr_en is honoured when !full or a read is accepted in the
// same cycle; rd_en is honoured when !empty; refused requests raise sticky errors.
interface sync_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_en, din, rd_en,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, din, rd_en,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl_mem.sv
// FIFO storage: flop array with one synchronous write port and an asynchronous read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, status flags, sticky errors,
// synchronous flush and a standard (registered) or first-word-fall-through read stage.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int         DATA_WIDTH    = 8,
  parameter int         DEPTH         = 16,
  parameter fifo_mode_e MODE          = FIFO_STD,
  parameter int         AFULL_THRESH  = DEPTH - 2,
  parameter int         AEMPTY_THRESH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  sync_fifo_ctrl_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AEMPTY_THRESH);

  if (DEPTH < 2) begin : g_chk_depth
    $fatal(1, "sync_fifo_ctrl: DEPTH must be >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_chk_afull
    $fatal(1, "sync_fifo_ctrl: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_chk_aempty
    $fatal(1, "sync_fifo_ctrl: AEMPTY_THRESH must be in 0..DEPTH-1");
  end

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_rd_fire;
  logic                  w_wr_fire;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_rd_acc  = bus.rd_en && !w_empty;
  // A full FIFO still takes a write when the same cycle frees a slot.
  assign w_wr_acc  = bus.wr_en && (!w_full || w_rd_acc);
  assign w_rd_fire = w_rd_acc && !bus.flush;
  assign w_wr_fire = w_wr_acc && !bus.flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_fire) r_wr_ptr <= PW'(ptr_inc(32'(r_wr_ptr), DEPTH));
      if (w_rd_fire) r_rd_ptr <= PW'(ptr_inc(32'(r_rd_ptr), DEPTH));
      case ({w_wr_fire, w_rd_fire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (bus.wr_en && !w_wr_acc) r_overflow  <= 1'b1;
      if (bus.rd_en && !w_rd_acc) r_underflow <= 1'b1;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_wr_fire),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.din),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  if (MODE == FIFO_STD) begin : g_std
    logic [DATA_WIDTH-1:0] r_dout;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)          r_dout <= '0;
      else if (bus.flush) r_dout <= '0;
      else if (w_rd_fire) r_dout <= w_mem_rdata;
    end

    assign bus.dout = r_dout;
  end else begin : g_fwft
    // Head word is visible straight from storage; meaningless while empty.
    assign bus.dout = w_mem_rdata;
  end

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= AF_CNT);
  assign bus.almost_empty = (r_count <= AE_CNT);
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: one STD and one FWFT instance against a queue-based model.
module tb_sync_fifo_ctrl;
  import sync_fifo_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int AFT   = 4;
  localparam int AET   = 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) s_if ();
  sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) f_if ();

  sync_fifo_ctrl #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .MODE(FIFO_STD),
    .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)
  ) u_std (.clk(clk), .rstn(rstn), .bus(s_if));

  sync_fifo_ctrl #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .MODE(FIFO_FWFT),
    .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)
  ) u_fwft (.clk(clk), .rstn(rstn), .bus(f_if));

  // clock / reset
  always #5 clk = ~clk;

  // model state: contents as queues, plus sticky flags and the STD output register
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] fw_q[$];
  logic [DW-1:0] s_dout = '0;
  bit s_ovf = 1'b0, s_unf = 1'b0, f_ovf = 1'b0, f_unf = 1'b0;
  bit rd_ok, wr_ok;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    fw_q.delete();
    s_dout = '0;
    s_ovf = 1'b0; s_unf = 1'b0; f_ovf = 1'b0; f_unf = 1'b0;
  endtask

  // one clock of FIFO behaviour, evaluated on the inputs the DUTs just sampled
  task automatic model_step();
    if (!rstn) return;
    if (s_if.flush) begin
      exp_q.delete(); s_dout = '0; s_ovf = 1'b0; s_unf = 1'b0;
    end else begin
      rd_ok = s_if.rd_en && (exp_q.size() > 0);
      wr_ok = s_if.wr_en && (exp_q.size() < DEPTH || rd_ok);
      if (rd_ok) s_dout = exp_q.pop_front();
      if (wr_ok) exp_q.push_back(s_if.din);
      if (s_if.wr_en && !wr_ok) s_ovf = 1'b1;
      if (s_if.rd_en && !rd_ok) s_unf = 1'b1;
    end
    if (f_if.flush) begin
      fw_q.delete(); f_ovf = 1'b0; f_unf = 1'b0;
    end else begin
      rd_ok = f_if.rd_en && (fw_q.size() > 0);
      wr_ok = f_if.wr_en && (fw_q.size() < DEPTH || rd_ok);
      if (rd_ok) void'(fw_q.pop_front());
      if (wr_ok) fw_q.push_back(f_if.din);
      if (f_if.wr_en && !wr_ok) f_ovf = 1'b1;
      if (f_if.rd_en && !rd_ok) f_unf = 1'b1;
    end
  endtask

  // driver: sel=0 drives the STD instance, sel=1 the FWFT one; the other idles
  task automatic drv(input bit sel, input bit fl, input bit wr, input logic [7:0] d, input bit rd);
    s_if.flush = !sel && fl; s_if.wr_en = !sel && wr; s_if.din = d; s_if.rd_en = !sel && rd;
    f_if.flush = sel && fl;  f_if.wr_en = sel && wr;  f_if.din = d; f_if.rd_en = sel && rd;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // scoreboard compare on every falling edge
  always @(negedge clk) begin
    chk("std_count", 32'(s_if.count), 32'(exp_q.size()));
    chk("std_full", 32'(s_if.full), 32'(exp_q.size() == DEPTH));
    chk("std_empty", 32'(s_if.empty), 32'(exp_q.size() == 0));
    chk("std_afull", 32'(s_if.almost_full), 32'(exp_q.size() >= AFT));
    chk("std_aempty", 32'(s_if.almost_empty), 32'(exp_q.size() <= AET));
    chk("std_ovf", 32'(s_if.overflow), 32'(s_ovf));
    chk("std_unf", 32'(s_if.underflow), 32'(s_unf));
    chk("std_dout", 32'(s_if.dout), 32'(s_dout));
    chk("fw_count", 32'(f_if.count), 32'(fw_q.size()));
    chk("fw_full", 32'(f_if.full), 32'(fw_q.size() == DEPTH));
    chk("fw_empty", 32'(f_if.empty), 32'(fw_q.size() == 0));
    chk("fw_afull", 32'(f_if.almost_full), 32'(fw_q.size() >= AFT));
    chk("fw_aempty", 32'(f_if.almost_empty), 32'(fw_q.size() <= AET));
    chk("fw_ovf", 32'(f_if.overflow), 32'(f_ovf));
    chk("fw_unf", 32'(f_if.underflow), 32'(f_unf));
    if (fw_q.size() > 0) chk("fw_dout", 32'(f_if.dout), 32'(fw_q[0]));
  end

  initial begin
    s_if.flush = 0; s_if.wr_en = 0; s_if.din = '0; s_if.rd_en = 0;
    f_if.flush = 0; f_if.wr_en = 0; f_if.din = '0; f_if.rd_en = 0;
    rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(s_if.count), 32'd0);
    chk("rst_empty", 32'(s_if.empty), 32'd1);
    chk("rst_full", 32'(s_if.full), 32'd0);
    chk("rst_aempty", 32'(s_if.almost_empty), 32'd1);
    chk("rst_afull", 32'(s_if.almost_full), 32'd0);
    chk("rst_dout", 32'(s_if.dout), 32'd0);
    rstn = 1'b1;
    drv(0, 0, 0, 8'h00, 0);

    // FWFT: head word visible the cycle after its write, no read needed
    drv(1, 0, 1, 8'hA5, 0);
    chk("fw_lit_empty", 32'(f_if.empty), 32'd0);
    chk("fw_lit_a5", 32'(f_if.dout), 32'hA5);
    drv(1, 0, 1, 8'h5A, 0);
    chk("fw_lit_hold", 32'(f_if.dout), 32'hA5);
    drv(1, 0, 0, 8'h00, 1);
    chk("fw_lit_5a", 32'(f_if.dout), 32'h5A);
    drv(1, 0, 0, 8'h00, 0);

    // STD fill, overflow, drain
    for (int i = 0; i < 5; i++) begin
      drv(0, 0, 1, 8'(8'h11 + i), 0);
      if (i == 3) begin
        chk("lit_afull4", 32'(s_if.almost_full), 32'd1);
        chk("lit_full4", 32'(s_if.full), 32'd0);
      end
    end
    chk("lit_full5", 32'(s_if.full), 32'd1);
    drv(0, 0, 1, 8'h16, 0);
    chk("lit_ovf", 32'(s_if.overflow), 32'd1);
    chk("lit_cnt5", 32'(s_if.count), 32'd5);
    for (int i = 0; i < 5; i++) begin
      drv(0, 0, 0, 8'h00, 1);
      chk("lit_rd", 32'(s_if.dout), 32'(8'h11 + i));
    end
    chk("lit_empty", 32'(s_if.empty), 32'd1);

    // pointer wrap past DEPTH-1
    for (int i = 0; i < 3; i++) drv(0, 0, 1, 8'(8'h01 + i), 0);
    for (int i = 0; i < 3; i++) drv(0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) drv(0, 0, 1, 8'(8'h21 + i), 0);
    for (int i = 0; i < 5; i++) begin
      drv(0, 0, 0, 8'h00, 1);
      chk("lit_wrap", 32'(s_if.dout), 32'(8'h21 + i));
    end
    chk("lit_wrap_cnt", 32'(s_if.count), 32'd0);

    drv(0, 1, 0, 8'h00, 0);
    chk("lit_flush_ovf", 32'(s_if.overflow), 32'd0);

    // full with simultaneous read and write
    for (int i = 0; i < 5; i++) drv(0, 0, 1, 8'(8'h31 + i), 0);
    drv(0, 0, 1, 8'h30, 1);
    chk("lit_rw_cnt", 32'(s_if.count), 32'd5);
    chk("lit_rw_full", 32'(s_if.full), 32'd1);
    chk("lit_rw_ovf", 32'(s_if.overflow), 32'd0);
    chk("lit_rw_dout", 32'(s_if.dout), 32'h31);
    for (int i = 0; i < 4; i++) drv(0, 0, 0, 8'h00, 1);
    drv(0, 0, 0, 8'h00, 1);
    chk("lit_rw_last", 32'(s_if.dout), 32'h30);

    // empty with simultaneous read and write
    drv(0, 0, 1, 8'h40, 1);
    chk("lit_er_cnt", 32'(s_if.count), 32'd1);
    chk("lit_er_unf", 32'(s_if.underflow), 32'd1);
    chk("lit_er_dout", 32'(s_if.dout), 32'h30);
    drv(0, 0, 0, 8'h00, 1);
    chk("lit_er_rd", 32'(s_if.dout), 32'h40);

    // flush beats a concurrent write and clears the sticky error
    drv(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) drv(0, 0, 1, 8'(8'h51 + i), 0);
    drv(0, 0, 1, 8'h56, 0);
    drv(0, 0, 0, 8'h00, 1);
    drv(0, 0, 0, 8'h00, 1);
    chk("lit_pre_cnt", 32'(s_if.count), 32'd3);
    drv(0, 1, 1, 8'h77, 1);
    chk("lit_fl_cnt", 32'(s_if.count), 32'd0);
    chk("lit_fl_empty", 32'(s_if.empty), 32'd1);
    chk("lit_fl_ovf", 32'(s_if.overflow), 32'd0);
    chk("lit_fl_unf", 32'(s_if.underflow), 32'd0);
    drv(0, 0, 1, 8'h78, 0);
    drv(0, 0, 0, 8'h00, 1);
    chk("lit_fl_rd", 32'(s_if.dout), 32'h78);

    // asynchronous reset in the middle of a write burst
    for (int i = 0; i < 6; i++) drv(0, 0, 1, 8'(8'h90 + i), 0);
    drv(1, 0, 1, 8'hC3, 0);
    #1;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("arst_cnt", 32'(s_if.count), 32'd0);
    chk("arst_empty", 32'(s_if.empty), 32'd1);
    chk("arst_ovf", 32'(s_if.overflow), 32'd0);
    chk("arst_dout", 32'(s_if.dout), 32'd0);
    chk("arst_fw_empty", 32'(f_if.empty), 32'd1);
    drv(0, 0, 0, 8'h00, 0);
    rstn = 1'b1;
    repeat (2) drv(0, 0, 0, 8'h00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
